fifo_wr_arb: RTL

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

---
 rtl/fifo_wr_arb.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fifo_wr_arb.sv
// ============================================================================
// fifo_wr_arb : two-requester round-robin burst arbiter writing a shared FIFO
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fifo_wr_arb #(
  parameter int DATA_W    = 64,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              fifo_full,
  output logic              fifo_wen,
  output logic [DATA_W-1:0] fifo_wdata,
  output logic [1:0]        grant,
  output logic [31:0]       xfer_cnt
);

  localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        last_owner_q, last_owner_d;  // 0 = req0, 1 = req1
  logic [3:0]  beat_q, beat_d;
  logic [31:0] xfer_cnt_q, xfer_cnt_d;

  logic              own1;
  logic              own_valid;
  logic              other_valid;
  logic [DATA_W-1:0] own_data;
  logic              release_arb;
  logic              burst_end;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      beat_q       <= 4'd0;
      xfer_cnt_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      beat_q       <= beat_d;
      xfer_cnt_q   <= xfer_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    beat_d       = beat_q;
    xfer_cnt_d   = xfer_cnt_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    fifo_wen     = 1'b0;
    fifo_wdata   = '0;
    own1         = (state_q == GNT1);
    own_valid    = 1'b0;
    other_valid  = 1'b0;
    own_data     = '0;
    release_arb  = 1'b0;
    burst_end    = 1'b0;

    case (state_q)
      IDLE: begin
        beat_d = 4'd0;
        if (req0_valid && req1_valid) begin
          state_d      = last_owner_q ? GNT0 : GNT1;
          last_owner_d = ~last_owner_q;
        end else if (req0_valid) begin
          state_d      = GNT0;
          last_owner_d = 1'b0;
        end else if (req1_valid) begin
          state_d      = GNT1;
          last_owner_d = 1'b1;
        end
      end

      GNT0, GNT1: begin
        own_valid   = own1 ? req1_valid : req0_valid;
        other_valid = own1 ? req0_valid : req1_valid;
        own_data    = own1 ? req1_data  : req0_data;
        req0_ready  = ~own1 & ~fifo_full;
        req1_ready  =  own1 & ~fifo_full;
        fifo_wen    = own_valid & ~fifo_full;
        fifo_wdata  = own_data;

        // A full FIFO freezes the grant, even if the owner drops valid.
        if (!fifo_full) begin
          if (!own_valid) begin
            release_arb = 1'b1;
          end else begin
            xfer_cnt_d = xfer_cnt_q + 32'd1;
            if (beat_q == LAST_BEAT) begin
              release_arb = 1'b1;
              burst_end   = 1'b1;
            end else begin
              beat_d = beat_q + 4'd1;
            end
          end
        end

        if (release_arb) begin
          beat_d = 4'd0;
          if (other_valid) begin
            state_d      = own1 ? GNT0 : GNT1;
            last_owner_d = ~own1;
          end else if (!burst_end) begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign grant    = {state_q == GNT1, state_q == GNT0};
  assign xfer_cnt = xfer_cnt_q;

endmodule

`default_nettype wire
